// File: rtl/fact_pkg.sv
// Shared types and default widths for the iterative factorial engine.
// Optional overflow detection is enabled with FACT_OVF_DETECT_EN.
package fact_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fact_state_t;

    localparam int FACT_N_W       = 5;
    localparam int FACT_OUT_W     = 64;
    // Largest n whose factorial fits in FACT_OUT_W bits
    localparam int FACT_MAX_EXACT = 20;

endpackage

// File: rtl/fact_mul_step.sv
// One iteration of the factorial loop: acc*cnt truncated to OUT_W bits.
// With FACT_OVF_DETECT_EN an overflow flag reports lost upper product bits.
module fact_mul_step
    import fact_pkg::*;
#(
    parameter int N_W   = FACT_N_W,
    parameter int OUT_W = FACT_OUT_W
) (
    input  logic [OUT_W-1:0] i_acc,
    input  logic [N_W:0]     i_cnt,
`ifdef FACT_OVF_DETECT_EN
    output logic             o_ovf,
`endif
    output logic [OUT_W-1:0] o_prod
);

`ifdef FACT_OVF_DETECT_EN
    logic [OUT_W+N_W:0] w_full;

    assign w_full = {{(N_W+1){1'b0}}, i_acc} * {{OUT_W{1'b0}}, i_cnt};
    assign o_prod = w_full[OUT_W-1:0];
    assign o_ovf  = |w_full[OUT_W+N_W:OUT_W];
`else
    // Only the kept bits are formed; the result wraps modulo 2^OUT_W
    assign o_prod = i_acc * {{(OUT_W-N_W-1){1'b0}}, i_cnt};
`endif

endmodule

// File: rtl/fact_seq_engine.sv
// Handshaked factorial engine: accepts n, multiplies once per clock, holds n! until taken.
// Define FACT_OVF_DETECT_EN to flag results that exceeded OUT_W bits on out_ovf.
module fact_seq_engine
    import fact_pkg::*;
#(
    parameter int N_W   = FACT_N_W,
    parameter int OUT_W = FACT_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_W-1:0]   in_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_fact,
    output logic             out_ovf
);

    fact_state_t      r_state;
    logic [N_W-1:0]   r_n;
    logic [OUT_W-1:0] r_acc;
    // One bit wider than n so the loop exits cleanly at n = 2^N_W-1
    logic [N_W:0]     r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [OUT_W-1:0] r_out_fact;
    logic [OUT_W-1:0] w_prod;
    logic             w_last;

    assign w_last = r_cnt > {1'b0, r_n};

`ifdef FACT_OVF_DETECT_EN
    logic r_ovf;
    logic r_out_ovf;
    logic w_mul_ovf;

    fact_mul_step #(.N_W(N_W), .OUT_W(OUT_W)) u_mul (
        .i_acc  (r_acc),
        .i_cnt  (r_cnt),
        .o_ovf  (w_mul_ovf),
        .o_prod (w_prod)
    );

    assign out_ovf = r_out_ovf;
`else
    fact_mul_step #(.N_W(N_W), .OUT_W(OUT_W)) u_mul (
        .i_acc  (r_acc),
        .i_cnt  (r_cnt),
        .o_prod (w_prod)
    );

    assign out_ovf = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_n         <= '0;
            r_acc       <= OUT_W'(1);
            r_cnt       <= (N_W+1)'(2);
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_fact  <= '0;
`ifdef FACT_OVF_DETECT_EN
            r_ovf       <= 1'b0;
            r_out_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_n        <= in_n;
                        r_acc      <= OUT_W'(1);
                        r_cnt      <= (N_W+1)'(2);
                        r_in_ready <= 1'b0;
                        r_state    <= CALC;
`ifdef FACT_OVF_DETECT_EN
                        r_ovf      <= 1'b0;
`endif
                    end
                end
                CALC: begin
                    if (w_last) begin
                        r_out_fact  <= r_acc;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
`ifdef FACT_OVF_DETECT_EN
                        r_out_ovf   <= r_ovf;
`endif
                    end else begin
                        r_acc <= w_prod;
                        r_cnt <= r_cnt + 1'b1;
`ifdef FACT_OVF_DETECT_EN
                        r_ovf <= r_ovf | w_mul_ovf;
`endif
                    end
                end
                DONE: begin
                    // in_ready returns one cycle after the output handshake
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_fact  = r_out_fact;

endmodule
